// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the fetch PC, issues halfword reads and queues fetched words for ID.
// Latency: a word is visible on o_ir_id two cycles after its read is issued (issue, response capture, present).
// Backpressure: i_stall_id holds the queue head; issue stops once queued plus in-flight words reach DEPTH.
module fetch_stage #(
  parameter int                 ADDR_W   = 16,
  parameter int                 DEPTH    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [15:0]        NOP_IR   = 16'hBF00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        i_addr_mode,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_stall_id,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [15:0]       i_mem_rdata,
  output logic [15:0]       o_ir_id,
  output logic              o_ir_valid,
  output logic [ADDR_W-1:0] o_pc_id
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]             pc_q, pc_d;
  logic [ADDR_W-1:0]             inflight_pc_q, inflight_pc_d;
  logic                          inflight_q, inflight_d;
  logic                          discard_q, discard_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [PTR_W-1:0]              rptr_q, rptr_d;
  logic [PTR_W-1:0]              wptr_q, wptr_d;
  logic [DEPTH-1:0][15:0]        ir_q, ir_d;
  logic [DEPTH-1:0][ADDR_W-1:0]  qpc_q, qpc_d;

  logic              redirect;
  logic              issue;
  logic              wr_en;
  logic              pop;
  logic [CNT_W:0]    occupancy;

  // Port arbitration, issue credit and queue handshake decisions for this cycle
  always_comb begin
    redirect  = (i_addr_mode == 2'b10);
    // Pops this cycle do not free credit: occupancy counts current entries plus the outstanding read
    occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    issue     = (i_addr_mode == 2'b00) && (occupancy < DEPTH_OCC) && !rst;
    wr_en     = inflight_q && !discard_q && !redirect;
    pop       = (count_q != '0) && !i_stall_id && !redirect;
  end

  // Memory request and head-of-queue presentation to ID
  always_comb begin
    o_mem_rd_en = issue;
    o_mem_addr  = pc_q;
    o_ir_valid  = (count_q != '0);
    o_ir_id     = o_ir_valid ? ir_q[rptr_q]  : NOP_IR;
    o_pc_id     = o_ir_valid ? qpc_q[rptr_q] : '0;
  end

  // Next-state: PC advance, in-flight tracking, queue write/pop, redirect flush
  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    discard_d     = 1'b0;
    count_d       = count_q;
    rptr_d        = rptr_q;
    wptr_d        = wptr_q;
    ir_d          = ir_q;
    qpc_d         = qpc_q;

    if (issue) begin
      pc_d          = pc_q + ADDR_W'(2);
      inflight_pc_d = pc_q;
      inflight_d    = 1'b1;
    end

    if (redirect) begin
      // Redirect wins over everything; a read already outstanding must not land later
      pc_d      = {i_branch_target[ADDR_W-1:1], 1'b0};
      discard_d = inflight_q;
      count_d   = '0;
      rptr_d    = '0;
      wptr_d    = '0;
    end else begin
      if (wr_en) begin
        ir_d[wptr_q]  = i_mem_rdata;
        qpc_d[wptr_q] = inflight_pc_q;
        wptr_d        = wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      discard_q     <= 1'b0;
      count_q       <= '0;
      rptr_q        <= '0;
      wptr_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rptr_q        <= rptr_d;
      wptr_q        <= wptr_d;
    end
  end

  // Queue storage; contents are only meaningful under count_q so no reset needed
  always_ff @(posedge clk) begin
    ir_q  <= ir_d;
    qpc_q <= qpc_d;
  end

  // The issue credit rule must make a write into a full queue unreachable
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(wr_en && (count_q == DEPTH_CNT)));
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: startup, stall, redirect, data-access window, PC wrap and reset mid-branch.
// Two instances share stimulus: RESET_PC=0000 (main) and RESET_PC=FFFC (wrap check).
// Memory models return 0x1000 + addr/2 one cycle after each read, 0xDEAD otherwise.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'hBF00;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_addr_mode;
  logic [15:0] i_branch_target;
  logic        i_stall_id;

  logic        rd_a, rd_b, vld_a, vld_b;
  logic [15:0] addr_a, addr_b, ir_a, ir_b, pc_a, pc_b;
  logic [15:0] rdata_a, rdata_b;

  int passed = 0;
  int total  = 0;
  int cyc    = -3;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(16), .DEPTH(2), .RESET_PC(16'h0000), .NOP_IR(16'hBF00)) dut_a (
    .clk(clk), .rst(rst), .i_addr_mode(i_addr_mode), .i_branch_target(i_branch_target),
    .i_stall_id(i_stall_id), .o_mem_rd_en(rd_a), .o_mem_addr(addr_a), .i_mem_rdata(rdata_a),
    .o_ir_id(ir_a), .o_ir_valid(vld_a), .o_pc_id(pc_a)
  );

  fetch_stage #(.ADDR_W(16), .DEPTH(2), .RESET_PC(16'hFFFC), .NOP_IR(16'hBF00)) dut_b (
    .clk(clk), .rst(rst), .i_addr_mode(i_addr_mode), .i_branch_target(i_branch_target),
    .i_stall_id(i_stall_id), .o_mem_rd_en(rd_b), .o_mem_addr(addr_b), .i_mem_rdata(rdata_b),
    .o_ir_id(ir_b), .o_ir_valid(vld_b), .o_pc_id(pc_b)
  );

  // Single-port memory models: read data valid the cycle after the request
  always @(posedge clk) begin
    rdata_a <= rd_a ? (16'h1000 + (addr_a >> 1)) : 16'hDEAD;
    rdata_b <= rd_b ? (16'h1000 + (addr_b >> 1)) : 16'hDEAD;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic [1:0] m, input logic s, input logic [15:0] t);
    @(negedge clk);
    rst             = r;
    i_addr_mode     = m;
    i_stall_id      = s;
    i_branch_target = t;
    #1;
    cyc++;
  endtask

  task automatic exp_a(input logic rd, input logic [15:0] addr, input logic vld,
                       input logic [15:0] ir, input logic [15:0] pc);
    chk($sformatf("a.c%0d.rd_en", cyc), 32'(rd_a), 32'(rd));
    chk($sformatf("a.c%0d.addr", cyc), 32'(addr_a), 32'(addr));
    chk($sformatf("a.c%0d.valid", cyc), 32'(vld_a), 32'(vld));
    chk($sformatf("a.c%0d.ir", cyc), 32'(ir_a), 32'(ir));
    chk($sformatf("a.c%0d.pc", cyc), 32'(pc_a), 32'(pc));
  endtask

  task automatic exp_b(input logic rd, input logic [15:0] addr, input logic vld,
                       input logic [15:0] ir, input logic [15:0] pc);
    chk($sformatf("b.c%0d.rd_en", cyc), 32'(rd_b), 32'(rd));
    chk($sformatf("b.c%0d.addr", cyc), 32'(addr_b), 32'(addr));
    chk($sformatf("b.c%0d.valid", cyc), 32'(vld_b), 32'(vld));
    chk($sformatf("b.c%0d.ir", cyc), 32'(ir_b), 32'(ir));
    chk($sformatf("b.c%0d.pc", cyc), 32'(pc_b), 32'(pc));
  endtask

  initial begin
    rst             = 1'b1;
    i_addr_mode     = 2'b00;
    i_stall_id      = 1'b0;
    i_branch_target = 16'h0000;

    // Reset: no request while rst is high, queue empty
    step(1, 2'b00, 0, 16'h0000);
    step(1, 2'b00, 0, 16'h0000);
    exp_a(0, 16'h0000, 0, NOP, 16'h0000);
    exp_b(0, 16'hFFFC, 0, NOP, 16'h0000);

    // Startup, no stalls; the second instance wraps FFFE -> 0000
    step(0, 2'b00, 0, 16'h0000);  // c0
    exp_a(1, 16'h0000, 0, NOP, 16'h0000);
    exp_b(1, 16'hFFFC, 0, NOP, 16'h0000);
    step(0, 2'b00, 0, 16'h0000);  // c1
    exp_a(1, 16'h0002, 0, NOP, 16'h0000);
    exp_b(1, 16'hFFFE, 0, NOP, 16'h0000);
    step(0, 2'b00, 0, 16'h0000);  // c2: count 1 + in-flight 1 blocks issue
    exp_a(0, 16'h0004, 1, 16'h1000, 16'h0000);
    exp_b(0, 16'h0000, 1, 16'h8FFE, 16'hFFFC);
    step(0, 2'b00, 0, 16'h0000);  // c3
    exp_a(1, 16'h0004, 1, 16'h1001, 16'h0002);
    exp_b(1, 16'h0000, 1, 16'h8FFF, 16'hFFFE);
    step(0, 2'b00, 0, 16'h0000);  // c4
    exp_a(1, 16'h0006, 0, NOP, 16'h0000);
    exp_b(1, 16'h0002, 0, NOP, 16'h0000);
    step(0, 2'b00, 0, 16'h0000);  // c5
    exp_a(0, 16'h0008, 1, 16'h1002, 16'h0004);
    exp_b(0, 16'h0004, 1, 16'h1000, 16'h0000);
    step(0, 2'b00, 0, 16'h0000);  // c6
    exp_a(1, 16'h0008, 1, 16'h1003, 16'h0006);
    exp_b(1, 16'h0004, 1, 16'h1001, 16'h0002);
    step(0, 2'b00, 0, 16'h0000);  // c7
    exp_a(1, 16'h000A, 0, NOP, 16'h0000);

    // Stall ID for 5 cycles: queue fills to 2, requests stop, head holds
    step(0, 2'b00, 1, 16'h0000);  // c8
    exp_a(0, 16'h000C, 1, 16'h1004, 16'h0008);
    for (int i = 0; i < 4; i++) begin  // c9..c12
      step(0, 2'b00, 1, 16'h0000);
      exp_a(0, 16'h000C, 1, 16'h1004, 16'h0008);
    end
    step(0, 2'b00, 0, 16'h0000);  // c13: full queue, still no issue
    exp_a(0, 16'h000C, 1, 16'h1004, 16'h0008);
    step(0, 2'b00, 0, 16'h0000);  // c14
    exp_a(1, 16'h000C, 1, 16'h1005, 16'h000A);
    step(0, 2'b00, 0, 16'h0000);  // c15
    exp_a(1, 16'h000E, 0, NOP, 16'h0000);

    // Redirect with a response arriving and a queued word; then back-to-back redirects
    step(0, 2'b10, 1, 16'h0041);  // c16
    exp_a(0, 16'h0010, 1, 16'h1006, 16'h000C);
    step(0, 2'b10, 0, 16'h0123);  // c17
    exp_a(0, 16'h0040, 0, NOP, 16'h0000);
    step(0, 2'b10, 0, 16'h0041);  // c18: last target wins
    exp_a(0, 16'h0122, 0, NOP, 16'h0000);
    step(0, 2'b00, 0, 16'h0000);  // c19
    exp_a(1, 16'h0040, 0, NOP, 16'h0000);
    step(0, 2'b00, 0, 16'h0000);  // c20
    exp_a(1, 16'h0042, 0, NOP, 16'h0000);
    step(0, 2'b00, 0, 16'h0000);  // c21
    exp_a(0, 16'h0044, 1, 16'h1020, 16'h0040);

    // Data-access window (01, 01, 11): no requests, queue keeps draining
    step(0, 2'b01, 0, 16'h0000);  // c22
    exp_a(0, 16'h0044, 1, 16'h1021, 16'h0042);
    step(0, 2'b01, 0, 16'h0000);  // c23
    exp_a(0, 16'h0044, 0, NOP, 16'h0000);
    step(0, 2'b11, 0, 16'h0000);  // c24
    exp_a(0, 16'h0044, 0, NOP, 16'h0000);
    step(0, 2'b00, 0, 16'h0000);  // c25: resumes with no PC skip
    exp_a(1, 16'h0044, 0, NOP, 16'h0000);
    step(0, 2'b01, 0, 16'h0000);  // c26: response still captured under 01
    exp_a(0, 16'h0046, 0, NOP, 16'h0000);
    step(0, 2'b00, 0, 16'h0000);  // c27
    exp_a(1, 16'h0046, 1, 16'h1022, 16'h0044);
    step(0, 2'b00, 0, 16'h0000);  // c28
    exp_a(1, 16'h0048, 0, NOP, 16'h0000);
    step(0, 2'b00, 0, 16'h0000);  // c29
    exp_a(0, 16'h004A, 1, 16'h1023, 16'h0046);
    step(0, 2'b00, 0, 16'h0000);  // c30
    exp_a(1, 16'h004A, 1, 16'h1024, 16'h0048);

    // Reset during a redirect with a fetch in flight
    step(1, 2'b10, 0, 16'h0200);  // c31
    exp_a(0, 16'h004C, 0, NOP, 16'h0000);
    step(0, 2'b00, 0, 16'h0000);  // c32
    exp_a(1, 16'h0000, 0, NOP, 16'h0000);
    exp_b(1, 16'hFFFC, 0, NOP, 16'h0000);
    step(0, 2'b00, 0, 16'h0000);  // c33
    exp_a(1, 16'h0002, 0, NOP, 16'h0000);
    step(0, 2'b00, 0, 16'h0000);  // c34
    exp_a(0, 16'h0004, 1, 16'h1000, 16'h0000);
    step(0, 2'b00, 0, 16'h0000);  // c35
    exp_a(1, 16'h0004, 1, 16'h1001, 16'h0002);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
